// File: rtl/cnt_pkg.sv
// Shared definitions for the loadable up-counter and its checker.
//   chk_state_e : checker FSM encoding (SYNC, TRACK, MISS)
//   CNT_W       : default counter/data width
//   next_count  : the one reference model of the counter's next value,
//                 used by both the counter RTL and the checker
package cnt_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    MISS  = 2'd2
  } chk_state_e;

  // Load wins over the increment, so a load on the wrap edge takes load_data.
  function automatic logic [CNT_W-1:0] next_count(
    input logic             load,
    input logic [CNT_W-1:0] load_data,
    input logic [CNT_W-1:0] base
  );
    return load ? load_data : base + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once the count is all ones)
//   clr   : synchronous clear, takes priority over inc
//   cnt   : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: give every always_comb output a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/counter_4bit_checker.sv
// Passive checker for a loadable free-running up-counter. It predicts the
// counter value every clock from the observed load/load_data, compares the
// prediction with the observed count and reports mismatches. It drives
// nothing back into the counter interface.
//   clk, reset_n : clock and asynchronous active-low reset shared with the counter
//   load         : observed load strobe
//   load_data    : observed load value
//   count        : observed counter output
//   clear_err    : synchronous clear of err_sticky and err_count
//   mismatch     : registered one-cycle pulse per detected mismatch
//   err_sticky   : set on the first mismatch, held until clear_err or reset
//   err_count    : saturating mismatch total
//   expected     : current prediction of count
//   state        : FSM state (0 SYNC, 1 TRACK, 2 MISS)
module counter_4bit_checker
  import cnt_pkg::*;
#(
  parameter int WIDTH     = CNT_W,
  parameter int ERR_CNT_W = 8,
  parameter bit RESYNC    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_data,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clear_err,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected,
  output logic [1:0]           state
);

  chk_state_e       state_q,    state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             mismatch_q, mismatch_d;
  logic             sticky_q,   sticky_d;
  logic [WIDTH-1:0] base;
  logic             miss;

  // The shared reference model is fixed at CNT_W; other widths use the
  // same rule written out locally.
  if (WIDTH == CNT_W) begin : g_shared_model
    always_comb expected_d = next_count(load, load_data, base);
  end else begin : g_local_model
    always_comb expected_d = load ? load_data : base + WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    base    = expected_q;
    // Case inequality so an X/Z on count is flagged in simulation.
    miss    = (state_q != SYNC) && (count !== expected_q);

    case (state_q)
      SYNC: begin
        // Nothing to compare against yet: adopt the observed count.
        base    = count;
        state_d = TRACK;
      end
      TRACK: begin
        base    = expected_q;
        state_d = miss ? MISS : TRACK;
      end
      MISS: begin
        base    = RESYNC ? count : expected_q;
        state_d = miss ? MISS : TRACK;
      end
      default: begin
        base    = count;
        state_d = SYNC;
      end
    endcase

    mismatch_d = miss;
    // Clear beats a simultaneous mismatch; the pulse itself is still emitted.
    sticky_d   = clear_err ? 1'b0 : (sticky_q | miss);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      expected_q <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_count (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (miss),
    .clr   (clear_err),
    .cnt   (err_count)
  );

  assign mismatch   = mismatch_q;
  assign err_sticky = sticky_q;
  assign expected   = expected_q;
  assign state      = state_q;

endmodule

// File: tb/tb_counter_4bit_checker.sv
// Directed bench for counter_4bit_checker. The bench plays the counter:
// it keeps the true counter value in cnt and drives it on count, or drives
// a forced value to provoke mismatches.
module tb_counter_4bit_checker;
  import cnt_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [3:0] load_data;
  logic [3:0] count;
  logic       clear_err;
  logic       mismatch;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [3:0] expected;
  logic [1:0] state;

  logic [3:0] cnt;
  int         checks;
  int         failures;

  counter_4bit_checker #(
    .WIDTH     (4),
    .ERR_CNT_W (8),
    .RESYNC    (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_data  (load_data),
    .count      (count),
    .clear_err  (clear_err),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .expected   (expected),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock of the modelled counter. frc drives frc_val on count instead
  // of the true value; the true counter itself still advances.
  task automatic tick(input logic ld, input logic [3:0] ld_data,
                      input logic frc, input logic [3:0] frc_val, input logic clr);
    load      = ld;
    load_data = ld_data;
    count     = frc ? frc_val : cnt;
    clear_err = clr;
    @(posedge clk);
    #1;
    cnt = ld ? ld_data : 4'(cnt + 4'd1);
  endtask

  task automatic free_tick();
    tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    load      = 1'b0;
    load_data = 4'h0;
    count     = 4'h0;
    clear_err = 1'b0;
    cnt       = 4'h0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_mismatch", 32'(mismatch),   32'(0));
    check("rst_sticky",   32'(err_sticky), 32'(0));
    check("rst_errcnt",   32'(err_count),  32'(0));
    check("rst_expected", 32'(expected),   32'(0));
    check("rst_state",    32'(state),      32'(SYNC));
    reset_n = 1'b1;

    // 1: free count, TRACK from the first edge, no mismatches
    for (int i = 0; i < 20; i++) begin
      free_tick();
      check("t1_state",    32'(state),    32'(TRACK));
      check("t1_mismatch", 32'(mismatch), 32'(0));
      check("t1_expected", 32'(expected), 32'((i + 1) & 15));
    end
    check("t1_errcnt", 32'(err_count), 32'(0));

    // 2: load 2, count to F, load of F+1, wrap, then load on the wrap edge
    tick(1'b1, 4'h2, 1'b0, 4'h0, 1'b0);
    check("t2_load2", 32'(expected), 32'(2));
    for (int k = 1; k <= 13; k++) begin
      free_tick();
      check("t2_up",          32'(expected), 32'(2 + k));
      check("t2_up_mismatch", 32'(mismatch), 32'(0));
    end
    tick(1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    check("t2_load_plus1",     32'(expected), 32'(0));
    check("t2_load_plus1_mis", 32'(mismatch), 32'(0));
    free_tick();
    check("t2_after_wrap", 32'(expected), 32'(1));
    for (int k = 1; k <= 14; k++) begin
      free_tick();
      check("t2_up2",          32'(expected), 32'(1 + k));
      check("t2_up2_mismatch", 32'(mismatch), 32'(0));
    end
    tick(1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
    check("t2_load_on_wrap", 32'(expected), 32'(7));
    check("t2_wrap_mismatch", 32'(mismatch), 32'(0));
    check("t2_errcnt",        32'(err_count), 32'(0));

    // 3: single forced 9 where 5 is expected
    tick(1'b1, 4'h4, 1'b0, 4'h0, 1'b0);
    free_tick();
    check("t3_pre_expected", 32'(expected), 32'(5));
    tick(1'b0, 4'h0, 1'b1, 4'h9, 1'b0);
    check("t3_mismatch", 32'(mismatch),   32'(1));
    check("t3_sticky",   32'(err_sticky), 32'(1));
    check("t3_errcnt",   32'(err_count),  32'(1));
    check("t3_state",    32'(state),      32'(MISS));
    check("t3_expected", 32'(expected),   32'(6));
    free_tick();
    check("t3_rec_mismatch", 32'(mismatch),   32'(0));
    check("t3_rec_state",    32'(state),      32'(TRACK));
    check("t3_rec_expected", 32'(expected),   32'(7));
    check("t3_rec_errcnt",   32'(err_count),  32'(1));
    check("t3_rec_sticky",   32'(err_sticky), 32'(1));

    // 4: 300 mismatches saturate err_count, then clear
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 4'h0, 1'b1, 4'h0, 1'b0);
      check("t4_mismatch", 32'(mismatch),  32'(1));
      check("t4_errcnt",   32'(err_count), 32'((i + 2 > 255) ? 255 : i + 2));
    end
    check("t4_state",    32'(state),    32'(MISS));
    check("t4_expected", 32'(expected), 32'(1));
    tick(1'b1, 4'h3, 1'b1, 4'h1, 1'b1);
    check("t4_clr_errcnt",   32'(err_count),  32'(0));
    check("t4_clr_sticky",   32'(err_sticky), 32'(0));
    check("t4_clr_mismatch", 32'(mismatch),   32'(0));
    check("t4_clr_state",    32'(state),      32'(TRACK));
    check("t4_clr_expected", 32'(expected),   32'(3));

    // 6: clear_err on the same edge as a mismatch
    tick(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    check("t6_mismatch", 32'(mismatch),   32'(1));
    check("t6_errcnt",   32'(err_count),  32'(0));
    check("t6_sticky",   32'(err_sticky), 32'(0));
    check("t6_state",    32'(state),      32'(MISS));
    free_tick();
    check("t6_rec_mismatch", 32'(mismatch),  32'(0));
    check("t6_rec_state",    32'(state),     32'(TRACK));
    check("t6_rec_expected", 32'(expected),  32'(5));
    check("t6_rec_errcnt",   32'(err_count), 32'(0));

    // 5: asynchronous reset between edges with error state set
    tick(1'b0, 4'h0, 1'b1, 4'h0, 1'b0);
    check("t5_pre_mismatch", 32'(mismatch),   32'(1));
    check("t5_pre_sticky",   32'(err_sticky), 32'(1));
    check("t5_pre_expected", 32'(expected),   32'(6));
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_mismatch", 32'(mismatch),   32'(0));
    check("t5_async_sticky",   32'(err_sticky), 32'(0));
    check("t5_async_errcnt",   32'(err_count),  32'(0));
    check("t5_async_expected", 32'(expected),   32'(0));
    check("t5_async_state",    32'(state),      32'(SYNC));
    load      = 1'b0;
    clear_err = 1'b0;
    count     = 4'h0;
    @(posedge clk);
    #1;
    cnt     = 4'h0;
    reset_n = 1'b1;
    check("t5_rel_state",    32'(state),    32'(SYNC));
    check("t5_rel_expected", 32'(expected), 32'(0));
    free_tick();
    check("t5_e1_state",    32'(state),    32'(TRACK));
    check("t5_e1_expected", 32'(expected), 32'(1));
    free_tick();
    check("t5_e2_expected", 32'(expected), 32'(2));
    check("t5_e2_mismatch", 32'(mismatch), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
